// File: rtl/result_capture_fifo.sv
// result_capture_fifo: downstream capture stage of the circuit5 datapath.
// Delays in_valid by the upstream latency so the matching {z, x} result can
// be captured into a small first-word-fall-through FIFO. The FIFO is drained
// over a valid/ready handshake. A result that arrives while the FIFO is full
// and not being popped is dropped, and a sticky overflow flag is set.
module result_capture_fifo #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATAWIDTH-1:0]           z,
  input  logic [DATAWIDTH-1:0]           x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATAWIDTH-1:0]           out_z,
  output logic [DATAWIDTH-1:0]           out_x,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [LATENCY-1:0]       vpipe;
  logic                     cap;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [2*DATAWIDTH-1:0]   mem [DEPTH];
  logic [2*DATAWIDTH-1:0]   head;

  // Pointer increment with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Valid pipe: cap goes high exactly LATENCY cycles after in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign cap       = vpipe[LATENCY-1];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot that the
  // incoming result then takes.
  assign push      = cap & (!full | pop);
  assign drop      = cap & full & !pop;

  // Storage array; it needs no reset because empty gates the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {z, x};
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Head word presented combinationally; forced to zero while empty.
  always_comb begin
    head  = mem[rd_ptr];
    out_z = '0;
    out_x = '0;
    if (!empty) begin
      out_z = head[2*DATAWIDTH-1:DATAWIDTH];
      out_x = head[DATAWIDTH-1:0];
    end
  end

endmodule
